// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states and a width sanity helper.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when a datapath width can be split into whole nibbles and spans at least two of them.
    function automatic bit width_ok(input int w);
        return ((w % NIBBLE_W) == 0) && (w >= 8);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Existing 4-bit ripple-carry adder stage: A + B + Cin -> Sum, Cout.
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign cout = c_s[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that sequences a single 4-bit ripple-carry stage one nibble per cycle, LSB first,
// with valid/ready handshakes on operands and result.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = $clog2(NIBBLES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic [NIBBLE_W-1:0] rca_sum_s;
    logic                rca_cout_s;

    ripple_carry_adder u_rca (
        .a    (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .b    (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .cin  (carry_q),
        .sum  (rca_sum_s),
        .cout (rca_cout_s)
    );

    // Next-state and datapath update for the IDLE/ADD/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = rca_sum_s;
                carry_d = rca_cout_s;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    // Overflow uses the latched operand signs and the freshly produced MSB.
                    cout_d  = rca_cout_s;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (rca_sum_s[NIBBLE_W-1] != a_q[WIDTH-1]);
                    valid_d = 1'b1;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = ADD;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised and directed bench for nibble_serial_adder (WIDTH=16) against an arithmetic reference model.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision addition, then split into {ovf, cout, sum}.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] t;
        logic        ov;
        t  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        ov = (a[15] == b[15]) && (t[15] != a[15]);
        return {ov, t[16], t[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation, wait for the result, optionally complete the output handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input bit noisy_ready, input bit do_hs,
                          output logic [15:0] s, output logic co, output logic ov,
                          output int lat, output bit timeout);
        for (int k = 0; k < 20 && !in_ready; k++) step();
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
        lat = 0;
        timeout = 1'b1;
        for (int k = 0; k < 20; k++) begin
            out_ready = noisy_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            lat++;
            if (out_valid) begin
                timeout = 1'b0;
                break;
            end
        end
        out_ready = 1'b0;
        s = out_sum; co = out_cout; ov = out_ovf;
        if (do_hs) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0000 ||
            out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h co=%b ov=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h5A5A};
        logic [15:0] tb [6] = '{16'h0000, 16'h0001, 16'h0001, 16'h8000, 16'hFFFF, 16'hA5A5};
        logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] es [6] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 16'hFFFF};
        logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        bit          to;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], tc[i], 1'b0, 1'b1, s, co, ov, lat, to);
            n_checks++;
            if (to || lat != 4) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles (timeout=%0d), want 4", i, lat, to);
            end
            n_checks++;
            if (s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b",
                         i, s, co, ov, es[i], ec[i], eo[i]);
            end
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_handshake[%0d]: got vld=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, s;
        logic        c, co, ov;
        logic [17:0] exp;
        int          lat;
        bit          to;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            exp = ref_add(a, b, c);
            run_op(a, b, c, 1'b1, 1'b1, s, co, ov, lat, to);
            n_checks++;
            if (to || lat != 4 || s !== exp[15:0] || co !== exp[16] || ov !== exp[17]) begin
                n_fail++;
                $display("FAIL random[%0d] %h+%h+%b: got sum=%h co=%b ov=%b lat=%0d, want sum=%h co=%b ov=%b lat=4",
                         i, a, b, c, s, co, ov, lat, exp[15:0], exp[16], exp[17]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] s;
        logic        co, ov;
        logic [17:0] exp;
        int          lat;
        bit          to;
        exp = ref_add(16'h9C3E, 16'hA7D1, 1'b1);
        run_op(16'h9C3E, 16'hA7D1, 1'b1, 1'b0, 1'b0, s, co, ov, lat, to);
        in_valid = 1'b1; in_a = 16'h0101; in_b = 16'h0202; in_cin = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (to || out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== exp[15:0] ||
                out_cout !== exp[16] || out_ovf !== exp[17]) begin
                n_fail++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b sum=%h co=%b ov=%b, want 1 0 %h %b %b",
                         k, out_valid, in_ready, out_sum, out_cout, out_ovf, exp[15:0], exp[16], exp[17]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_in_valid: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        bit          to;
        in_a = 16'hBEEF; in_b = 16'h1357; in_cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0000 ||
            out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b vld=%b sum=%h co=%b ov=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, s, co, ov, lat, to);
        n_checks++;
        if (to || lat != 4 || s !== 16'h2345 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_op: got sum=%h co=%b ov=%b lat=%0d, want 2345 0 0 4", s, co, ov, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000; in_cin = 1'b0; out_ready = 1'b0;
        #23;
        test_reset();
        rst_n = 1'b1;
        step();
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
